// File: rtl/adder_8bit.sv
// Registered WIDTH-bit adder with carry-in, carry-out, signed overflow and zero flags.
// 4-bit carry-lookahead groups with the group carries rippling between them; one-cycle latency.

module adder_8bit_cla4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is expanded from c_i, so no carry depends on a lower carry.
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_i);

  assign s_o = p ^ c[3:0];
  assign c_o = c[4];
endmodule

module adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             Zero,
  output logic             out_valid
);
  localparam int NGRP = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("adder_8bit: WIDTH must be a multiple of 4 and at least 4");
  end

  logic [NGRP:0]    gcarry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;
  logic             vld_q;

  assign gcarry[0] = Cin;

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    adder_8bit_cla4 u_cla4 (
      .a_i (A[4*g +: 4]),
      .b_i (B[4*g +: 4]),
      .c_i (gcarry[g]),
      .s_o (sum_d[4*g +: 4]),
      .c_o (gcarry[g+1])
    );
  end

  assign cout_d = gcarry[NGRP];
  // Signed overflow: operands agree in sign but the result does not.
  assign ovf_d  = (A[WIDTH-1] == B[WIDTH-1]) && (sum_d[WIDTH-1] != A[WIDTH-1]);
  assign zero_d = (sum_d == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;
  assign out_valid = vld_q;
endmodule

// File: tb/tb_adder_8bit.sv
// Scoreboard bench for adder_8bit: the driver queues expected results from an arithmetic
// model, and a monitor compares each one in the cycle it falls due.

module tb_adder_8bit;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] A, B;
  logic       Cin;
  logic [7:0] Sum;
  logic       Cout, Overflow, Zero, out_valid;

  adder_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .Cin(Cin),
    .Sum(Sum), .Cout(Cout), .Overflow(Overflow), .Zero(Zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       due;
    logic     v;
    logic [7:0] s;
    logic     co, ov, z;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // Model state: the result the DUT is expected to be holding.
  logic [7:0] hs;
  logic       hc, hv, hz;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each queued entry is compared on the falling edge of the cycle it is due.
  always @(negedge clk) begin
    if (!rst) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (out_valid !== e.v || Sum !== e.s || Cout !== e.co || Overflow !== e.ov || Zero !== e.z) begin
          failures++;
          $display("FAIL result cyc=%0d got v=%b s=%h co=%b ov=%b z=%b want v=%b s=%h co=%b ov=%b z=%b",
                   cyc, out_valid, Sum, Cout, Overflow, Zero, e.v, e.s, e.co, e.ov, e.z);
        end
      end else if (out_valid !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid cyc=%0d got out_valid=%b want 0", cyc, out_valid);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
    int full, ssum, sa, sb;
    exp_t e;
    @(posedge clk); #1;
    A = a; B = b; Cin = c; in_valid = v;
    if (v) begin
      full = int'(a) + int'(b) + int'(c);
      sa   = $signed(a);
      sb   = $signed(b);
      ssum = sa + sb + int'(c);
      hs   = full[7:0];
      hc   = (full >= 256);
      hv   = (ssum > 127) || (ssum < -128);
      hz   = (full[7:0] == 8'd0);
    end
    e.due = cyc + 1; e.v = v; e.s = hs; e.co = hc; e.ov = hv; e.z = hz;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (Sum !== 8'd0 || Cout !== 1'b0 || Overflow !== 1'b0 || Zero !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s got s=%h co=%b ov=%b z=%b v=%b want all 0", name, Sum, Cout, Overflow, Zero, out_valid);
    end
  endtask

  // Asserts reset just after an edge so a registered result is present, checks it clears
  // with no clock edge, and discards anything still in flight.
  task automatic do_reset(input string name);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_zero(name);
    q.delete();
    hs = '0; hc = 1'b0; hv = 1'b0; hz = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
    hs = '0; hc = 1'b0; hv = 1'b0; hz = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero("reset_initial");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Load a nonzero result, then reset over it.
    issue(8'hFF, 8'hFF, 1'b1, 1'b1);
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    do_reset("reset_async_clear");
    issue(8'd0,   8'd0,   1'b0, 1'b1);
    issue(8'd1,   8'd1,   1'b0, 1'b1);
    issue(8'd15,  8'd1,   1'b0, 1'b1);
    issue(8'd240, 8'd15,  1'b0, 1'b1);
    issue(8'd255, 8'd1,   1'b0, 1'b1);
    issue(8'd255, 8'd255, 1'b1, 1'b1);
    issue(8'd127, 8'd1,   1'b0, 1'b1);
    issue(8'd128, 8'd128, 1'b0, 1'b1);
    // Three back-to-back, then hold with changing don't-care operands.
    issue(8'd10,  8'd20,  1'b1, 1'b1);
    issue(8'd200, 8'd100, 1'b0, 1'b1);
    issue(8'd77,  8'd33,  1'b1, 1'b1);
    issue(8'hA5,  8'h5A,  1'b1, 1'b0);
    issue(8'h00,  8'hFF,  1'b0, 1'b0);
    issue(8'h3C,  8'hC3,  1'b1, 1'b0);

    // Reset in the middle of back-to-back traffic.
    issue(8'd99, 8'd1, 1'b0, 1'b1);
    do_reset("reset_mid_op");
    issue(8'd5, 8'd6, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0));
    end

    issue(8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #6;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
